// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the pc, fetches opcode and movi constant bytes,
// presents one instruction per EXEC cycle to the control unit.
module inst_fetch_unit #(
  parameter int          ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [4:0]  MOVI_OP  = 5'b00010
) (
  input  logic              clk,
  input  logic              rst,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memValid,
  input  logic [7:0]        memData,
  output logic [7:0]        inst,
  output logic              instValid,
  output logic [7:0]        constData,
  output logic              constValid,
  input  logic              loadAddr,
  input  logic [ADDR_W-1:0] jumpAddr,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [1:0] {
    FETCH_OP,
    FETCH_CONST,
    EXEC
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [7:0]        ir, ir_nxt;
  logic [7:0]        cr, cr_nxt;
  logic              accept;
  logic              exec;

  assign exec    = (state == EXEC) && !rst;
  assign memReq  = (state != EXEC) && !rst;
  assign memAddr = pc;
  assign accept  = memReq && memValid;

  assign inst       = exec ? ir : 8'h00;
  assign instValid  = exec;
  assign constData  = cr;
  assign constValid = exec && (ir[7:3] == MOVI_OP);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    cr_nxt    = cr;
    unique case (state)
      FETCH_OP: begin
        if (accept) begin
          ir_nxt = memData;
          pc_nxt = pc + 1'b1;
          if (memData[7:3] == MOVI_OP)
            state_nxt = FETCH_CONST;
          else
            state_nxt = EXEC;
        end
      end
      FETCH_CONST: begin
        if (accept) begin
          cr_nxt    = memData;
          pc_nxt    = pc + 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (loadAddr)
          pc_nxt = jumpAddr;
        state_nxt = FETCH_OP;
      end
      default: state_nxt = FETCH_OP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH_OP;
      pc    <= RESET_PC;
      ir    <= 8'h00;
      cr    <= 8'h00;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
      cr    <= cr_nxt;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a byte-array memory model.
// Inputs change #1 after the rising edge; outputs are checked there.
module tb_inst_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       memReq;
  logic [7:0] memAddr;
  logic       memValid;
  logic [7:0] memData;
  logic [7:0] inst;
  logic       instValid;
  logic [7:0] constData;
  logic       constValid;
  logic       loadAddr;
  logic [7:0] jumpAddr;
  logic [7:0] pc;

  logic [7:0] mem [256];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign memData = mem[memAddr];

  inst_fetch_unit #(
    .ADDR_W  (8),
    .RESET_PC(8'h00),
    .MOVI_OP (5'b00010)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .memReq    (memReq),
    .memAddr   (memAddr),
    .memValid  (memValid),
    .memData   (memData),
    .inst      (inst),
    .instValid (instValid),
    .constData (constData),
    .constValid(constValid),
    .loadAddr  (loadAddr),
    .jumpAddr  (jumpAddr),
    .pc        (pc)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst      = 1'b1;
    memValid = 1'b1;
    loadAddr = 1'b0;
    jumpAddr = 8'h00;

    // reset state and zero-wait add
    mem[0] = 8'h40;
    mem[1] = 8'h00;
    do_reset();
    chk("rst_memReq", memReq, 0);
    chk("rst_instValid", instValid, 0);
    chk("rst_inst", inst, 8'h00);
    chk("rst_constValid", constValid, 0);
    chk("rst_pc", pc, 8'h00);
    rst = 1'b0;
    #1;
    chk("c1_memReq", memReq, 1);
    chk("c1_memAddr", memAddr, 8'h00);
    tick();
    chk("c2_instValid", instValid, 1);
    chk("c2_inst", inst, 8'h40);
    chk("c2_constValid", constValid, 0);
    tick();
    chk("c3_memAddr", memAddr, 8'h01);
    chk("c3_instValid", instValid, 0);

    // movi with constant byte
    mem[0] = 8'h10;
    mem[1] = 8'hA5;
    mem[2] = 8'h40;
    mem[3] = 8'h48;
    mem[4] = 8'h68;
    do_reset();
    rst = 1'b0;
    tick();
    chk("movi_c2_instValid", instValid, 0);
    chk("movi_c2_memAddr", memAddr, 8'h01);
    tick();
    chk("movi_c3_instValid", instValid, 1);
    chk("movi_c3_inst", inst, 8'h10);
    chk("movi_c3_constValid", constValid, 1);
    chk("movi_c3_constData", constData, 8'hA5);
    tick();
    chk("movi_pc", pc, 8'h02);

    // wait states at pc=3
    tick();
    chk("add2_exec", instValid, 1);
    memValid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("wait_memReq", memReq, 1);
      chk("wait_memAddr", memAddr, 8'h03);
      chk("wait_instValid", instValid, 0);
      tick();
    end
    memValid = 1'b1;
    tick();
    chk("wait_exec_valid", instValid, 1);
    chk("wait_exec_inst", inst, 8'h48);
    tick();
    chk("wait_single_exec", instValid, 0);
    chk("wait_next_addr", memAddr, 8'h04);

    // jump in EXEC, ignored loadAddr in FETCH_OP
    tick();
    chk("jmp_exec_inst", inst, 8'h68);
    loadAddr = 1'b1;
    jumpAddr = 8'h20;
    tick();
    loadAddr = 1'b0;
    chk("jmp_memAddr", memAddr, 8'h20);
    chk("jmp_memReq", memReq, 1);
    memValid = 1'b0;
    loadAddr = 1'b1;
    jumpAddr = 8'h55;
    tick();
    loadAddr = 1'b0;
    chk("jmp_ignored_pc", pc, 8'h20);

    // wrap: movi at 0xFF, constant at 0x00
    mem[8'h20] = 8'h68;
    mem[8'hFF] = 8'h10;
    mem[0]     = 8'h3C;
    memValid = 1'b1;
    tick();
    chk("wrap_pre_exec", instValid, 1);
    loadAddr = 1'b1;
    jumpAddr = 8'hFF;
    tick();
    loadAddr = 1'b0;
    chk("wrap_op_addr", memAddr, 8'hFF);
    tick();
    chk("wrap_const_addr", memAddr, 8'h00);
    tick();
    chk("wrap_exec_inst", inst, 8'h10);
    chk("wrap_constData", constData, 8'h3C);
    chk("wrap_constValid", constValid, 1);
    tick();
    chk("wrap_pc", pc, 8'h01);

    // reset during FETCH_CONST with valid data
    mem[0] = 8'h10;
    mem[1] = 8'h77;
    do_reset();
    rst = 1'b0;
    tick();
    chk("rmid_in_const", memAddr, 8'h01);
    rst = 1'b1;
    #1;
    chk("rmid_memReq", memReq, 0);
    chk("rmid_instValid", instValid, 0);
    tick();
    chk("rmid_cr", constData, 8'h00);
    chk("rmid_pc", pc, 8'h00);
    chk("rmid_no_exec", instValid, 0);
    rst = 1'b0;
    #1;
    chk("rmid_refetch_req", memReq, 1);
    chk("rmid_refetch_addr", memAddr, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
